ddr3_cpu_req_gen: RTL and testbench

DDR3_CPU_REQ_GEN -- requirements
Module: ddr3_cpu_req_gen

---
 rtl/ddr3_cpu_req_gen_if.sv | 28 ++
 rtl/ddr3_cpu_req_gen.sv | 174 +++++++++++++++++
 tb/tb_ddr3_cpu_req_gen.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_cpu_req_gen_if.sv
// ddr3_cpu_req_gen_if: command/response bus between the request generator and
// the memory controller.
//   cmd_valid/cmd_ready  command handshake (generator -> controller)
//   cmd_addr/cmd_write/cmd_wdata  command payload
//   rd_valid/rd_data     in-order read responses (controller -> generator)
// Modports: master = generator side, slave = controller side.
interface ddr3_cpu_req_gen_if #(
    parameter int unsigned ADDR_W = 27,
    parameter int unsigned DATA_W = 64
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_write;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output cmd_valid, cmd_addr, cmd_write, cmd_wdata,
        input  cmd_ready, rd_valid, rd_data
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_write, cmd_wdata,
        output cmd_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/ddr3_cpu_req_gen.sv
// ddr3_cpu_req_gen: CPU-side traffic generator for a DDR3 controller. A start
// pulse in idle launches a run of cfg_count read or write requests at
// cfg_base, cfg_base+ADDR_STEP, ... (address wraps silently). Write data is
// cfg_pattern ^ address. Reads are throttled to MAX_OUT outstanding, and the
// run ends once every read has been answered.
// Ports:
//   cpu_clk, RESET_N          clock, asynchronous active-low reset
//   start, cfg_*              run launch and configuration (latched on start)
//   bus (master modport)      command handshake and read responses
//   busy, done                run in progress / one-cycle end-of-run pulse
//   err_cnt, rsp_cnt          saturating error and response counters
// Optional feature: define DDR3_CPU_RDCHECK_EN to compare each read response
// against cfg_pattern ^ address of the oldest outstanding read.
module ddr3_cpu_req_gen #(
    parameter int unsigned ADDR_W    = 27,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned MAX_OUT   = 4,
    parameter int unsigned ADDR_STEP = 8
) (
    input  logic                  cpu_clk,
    input  logic                  RESET_N,
    input  logic                  start,
    input  logic                  cfg_write,
    input  logic [ADDR_W-1:0]     cfg_base,
    input  logic [CNT_W-1:0]      cfg_count,
    input  logic [DATA_W-1:0]     cfg_pattern,
    ddr3_cpu_req_gen_if.master    bus,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      err_cnt,
    output logic [CNT_W-1:0]      rsp_cnt
);
    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StFinish} state_e;

    localparam logic [3:0] MaxOut = 4'(MAX_OUT);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] pattern_q, pattern_d;
    logic [CNT_W-1:0]  remain_q, remain_d;
    logic [CNT_W-1:0]  rsp_cnt_q, rsp_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [3:0]        outst_q, outst_d;

    logic cmd_valid, accept, acc_rd, rsp_ok, rd_mismatch, launch;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign launch    = (state_q == StIdle) && start;
    assign cmd_valid = (state_q == StIssue) && (write_q || (outst_q != MaxOut));
    assign accept    = cmd_valid && bus.cmd_ready;
    assign acc_rd    = accept && !write_q;
    // A response only counts against a read already in flight.
    assign rsp_ok    = bus.rd_valid && (outst_q != 4'd0);

`ifdef DDR3_CPU_RDCHECK_EN
    localparam int unsigned PtrW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MAX_OUT - 1);

    // Addresses of in-flight reads, oldest at rd_ptr_q; occupancy is outst_q.
    logic [ADDR_W-1:0] exp_mem [MAX_OUT];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (launch) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (acc_rd) wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
            if (rsp_ok) rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
        end
    end

    always_ff @(posedge cpu_clk or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (acc_rd) exp_mem[wr_ptr_q] <= addr_q;
    end

    assign rd_mismatch = rsp_ok && (bus.rd_data != (pattern_q ^ DATA_W'(exp_mem[rd_ptr_q])));
`else
    logic unused_rd_data;
    assign unused_rd_data = ^bus.rd_data;
    assign rd_mismatch    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        write_d   = write_q;
        pattern_d = pattern_q;
        remain_d  = remain_q;
        rsp_cnt_d = rsp_cnt_q;
        err_cnt_d = err_cnt_q;
        outst_d   = outst_q + 4'(acc_rd) - 4'(rsp_ok);

        if (rsp_ok) rsp_cnt_d = sat_inc(rsp_cnt_q);
        if ((bus.rd_valid && !rsp_ok) || rd_mismatch) err_cnt_d = sat_inc(err_cnt_q);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    write_d   = cfg_write;
                    pattern_d = cfg_pattern;
                    addr_d    = cfg_base;
                    remain_d  = cfg_count;
                    rsp_cnt_d = '0;
                    err_cnt_d = '0;
                    outst_d   = '0;
                    state_d   = (cfg_count == '0) ? StFinish : StIssue;
                end
            end
            StIssue: begin
                if (accept) begin
                    addr_d   = addr_q + ADDR_W'(ADDR_STEP);
                    remain_d = remain_q - CNT_W'(1);
                    if (remain_q == CNT_W'(1)) state_d = write_q ? StFinish : StDrain;
                end
            end
            StDrain: begin
                if (outst_q == 4'd0) state_d = StFinish;
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            write_q   <= 1'b0;
            pattern_q <= '0;
            remain_q  <= '0;
            rsp_cnt_q <= '0;
            err_cnt_q <= '0;
            outst_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            pattern_q <= pattern_d;
            remain_q  <= remain_d;
            rsp_cnt_q <= rsp_cnt_d;
            err_cnt_q <= err_cnt_d;
            outst_q   <= outst_d;
        end
    end

    assign bus.cmd_valid = cmd_valid;
    assign bus.cmd_addr  = addr_q;
    assign bus.cmd_write = write_q;
    assign bus.cmd_wdata = pattern_q ^ DATA_W'(addr_q);
    assign busy          = (state_q == StIssue) || (state_q == StDrain);
    assign done          = (state_q == StFinish);
    assign err_cnt       = err_cnt_q;
    assign rsp_cnt       = rsp_cnt_q;
endmodule

// File: tb/tb_ddr3_cpu_req_gen.sv
// Bench for ddr3_cpu_req_gen. Everything is sampled and driven on the falling
// clock edge. The model predicts the command stream from base/step arithmetic,
// keeps its own queue of in-flight read addresses, and answers reads in order.
module tb_ddr3_cpu_req_gen;
    localparam int unsigned ADDR_W    = 27;
    localparam int unsigned DATA_W    = 64;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned MAX_OUT   = 4;
    localparam int unsigned ADDR_STEP = 8;
`ifdef DDR3_CPU_RDCHECK_EN
    localparam bit RdCheck = 1'b1;
`else
    localparam bit RdCheck = 1'b0;
`endif

    logic              cpu_clk = 1'b0;
    logic              RESET_N = 1'b0;
    logic              start = 1'b0;
    logic              cfg_write = 1'b0;
    logic [ADDR_W-1:0] cfg_base = '0;
    logic [CNT_W-1:0]  cfg_count = '0;
    logic [DATA_W-1:0] cfg_pattern = '0;
    logic              busy, done;
    logic [CNT_W-1:0]  err_cnt, rsp_cnt;

    ddr3_cpu_req_gen_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ddr3_cpu_req_gen #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W),
        .MAX_OUT(MAX_OUT), .ADDR_STEP(ADDR_STEP)
    ) dut (
        .cpu_clk(cpu_clk), .RESET_N(RESET_N), .start(start), .cfg_write(cfg_write),
        .cfg_base(cfg_base), .cfg_count(cfg_count), .cfg_pattern(cfg_pattern),
        .bus(bus), .busy(busy), .done(done), .err_cnt(err_cnt), .rsp_cnt(rsp_cnt)
    );

    always #5 cpu_clk = ~cpu_clk;

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // i-th request address: base + i*step, modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] model_addr(input logic [ADDR_W-1:0] base, input int i);
        longint unsigned a;
        a = longint'(base) + longint'(i) * longint'(ADDR_STEP);
        return ADDR_W'(a % (64'd1 << ADDR_W));
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, 64'(bus.cmd_valid), 64'd0);
        chk({tag, "_write"}, 64'(bus.cmd_write), 64'd0);
        chk({tag, "_addr"},  64'(bus.cmd_addr),  64'd0);
        chk({tag, "_wdata"}, bus.cmd_wdata,      64'd0);
        chk({tag, "_busy"},  64'(busy),          64'd0);
        chk({tag, "_done"},  64'(done),          64'd0);
        chk({tag, "_err"},   64'(err_cnt),       64'd0);
        chk({tag, "_rsp"},   64'(rsp_cnt),       64'd0);
    endtask

    // One complete run. Called and returns on a falling edge.
    task automatic run(input bit wr, input logic [ADDR_W-1:0] base, input int cnt,
                       input logic [DATA_W-1:0] pat, input int ready_pct, input int rsp_pct,
                       input int hold_rsp, input int corrupt_idx);
        logic [ADDR_W-1:0] pend_q[$];
        logic [ADDR_W-1:0] a, prev_addr;
        logic [DATA_W-1:0] prev_wdata;
        bit   prev_stall, exp_valid, finished;
        int   n_acc, n_rsp, done_cyc, last_acc, last_rsp, t, exp_err, exp_rsp;
        n_acc = 0; n_rsp = 0; done_cyc = -1; last_acc = -1; last_rsp = -1;
        prev_stall = 1'b0; finished = 1'b0; prev_addr = '0; prev_wdata = '0;
        exp_rsp = wr ? 0 : cnt;
        exp_err = (!wr && RdCheck && corrupt_idx >= 0 && corrupt_idx < cnt) ? 1 : 0;

        cfg_write = wr; cfg_base = base; cfg_count = CNT_W'(cnt); cfg_pattern = pat;
        start = 1'b1;
        @(negedge cpu_clk);
        t = 0;
        while (!finished && t < 2000) begin
            // Scramble cfg and poke start: both must be ignored mid-run.
            cfg_write = 1'($urandom); cfg_base = ADDR_W'($urandom);
            cfg_count = CNT_W'($urandom); cfg_pattern = {$urandom, $urandom};
            start = 1'($urandom);

            exp_valid = (n_acc < cnt) && (wr || pend_q.size() < MAX_OUT);
            chk("cmd_valid", 64'(bus.cmd_valid), 64'(exp_valid));
            if (prev_stall) begin
                chk("hold_addr",  64'(bus.cmd_addr), 64'(prev_addr));
                chk("hold_wdata", bus.cmd_wdata,     prev_wdata);
            end
            if (hold_rsp > 0 && t == hold_rsp) begin
                chk("acc_before_rsp", 64'(n_acc), 64'((cnt < MAX_OUT) ? cnt : MAX_OUT));
            end
            if (done) begin
                done_cyc = t;
                finished = 1'b1;
                chk("busy_at_done", 64'(busy), 64'd0);
            end else begin
                bus.rd_valid = 1'b0;
                if (t >= hold_rsp && pend_q.size() > 0 && $urandom_range(99) < rsp_pct) begin
                    a = pend_q.pop_front();
                    bus.rd_data = pat ^ DATA_W'(a);
                    if (n_rsp == corrupt_idx) bus.rd_data = bus.rd_data ^ 64'h10;
                    bus.rd_valid = 1'b1;
                    n_rsp++;
                    last_rsp = t;
                end
                bus.cmd_ready = ($urandom_range(99) < ready_pct);
                prev_stall = bus.cmd_valid && !bus.cmd_ready;
                prev_addr  = bus.cmd_addr;
                prev_wdata = bus.cmd_wdata;
                if (bus.cmd_valid && bus.cmd_ready) begin
                    chk("acc_in_range", 64'(n_acc < cnt), 64'd1);
                    a = model_addr(base, n_acc);
                    chk("cmd_addr",  64'(bus.cmd_addr),  64'(a));
                    chk("cmd_write", 64'(bus.cmd_write), 64'(wr));
                    chk("cmd_wdata", bus.cmd_wdata,      pat ^ DATA_W'(a));
                    chk("busy_issue", 64'(busy),         64'd1);
                    if (!wr) pend_q.push_back(a);
                    n_acc++;
                    last_acc = t;
                end
                @(negedge cpu_clk);
                t++;
            end
        end
        start = 1'b0; bus.rd_valid = 1'b0; bus.cmd_ready = 1'b0;

        chk("done_seen", 64'(finished), 64'd1);
        chk("n_acc", 64'(n_acc), 64'(cnt));
        chk("n_rsp", 64'(n_rsp), 64'(exp_rsp));
        if (cnt == 0) chk("done_lat_zero", 64'(done_cyc), 64'd0);
        else if (wr) chk("done_lat_wr", 64'(done_cyc - last_acc), 64'd1);
        else chk("done_after_rsp", 64'(done_cyc > last_rsp && done_cyc <= last_rsp + 3), 64'd1);
        chk("rsp_cnt", 64'(rsp_cnt), 64'(exp_rsp));
        chk("err_cnt", 64'(err_cnt), 64'(exp_err));
        @(negedge cpu_clk);
        chk("done_pulse", 64'(done), 64'd0);
        chk("busy_idle", 64'(busy), 64'd0);
        chk("idle_valid", 64'(bus.cmd_valid), 64'd0);
    endtask

    initial begin
        bus.cmd_ready = 1'b0;
        bus.rd_valid  = 1'b0;
        bus.rd_data   = '0;
        #2;
        chk_reset_vals("por");
        @(negedge cpu_clk);
        RESET_N = 1'b1;
        @(negedge cpu_clk);

        // Directed write run, ready tied high.
        run(1'b1, 27'h100, 3, 64'hA5A5, 100, 0, 0, -1);

        // Unsolicited response in idle counts as an error only.
        bus.rd_valid = 1'b1;
        @(negedge cpu_clk);
        bus.rd_valid = 1'b0;
        chk("unsol_err", 64'(err_cnt), 64'd1);
        chk("unsol_rsp", 64'(rsp_cnt), 64'd0);
        @(negedge cpu_clk);

        // Read run with responses withheld: throttles at MAX_OUT.
        run(1'b0, 27'h2000, 6, 64'h1234_5678_9ABC_DEF0, 100, 100, 20, -1);

        // Zero-length run.
        run(1'b1, 27'h40, 0, 64'h0, 100, 0, 0, -1);

        // Address wrap, write and read.
        run(1'b1, 27'h7FF_FFF8, 2, 64'hFFFF_0000_FFFF_0000, 100, 0, 0, -1);
        run(1'b0, 27'h7FF_FFF8, 2, 64'h0F0F, 70, 60, 0, -1);

        // Second of three responses corrupted.
        run(1'b0, 27'h300, 3, 64'hCAFE_F00D, 100, 100, 0, 1);

        // Randomized runs.
        for (int r = 0; r < 10; r++) begin
            automatic int c = int'($urandom_range(12, 1));
            run(1'($urandom), ADDR_W'($urandom), c, {$urandom, $urandom},
                int'($urandom_range(90, 30)), int'($urandom_range(90, 20)), 0,
                (r % 3 == 0) ? int'($urandom_range(c - 1, 0)) : -1);
        end

        // Reset during drain with two reads in flight.
        cfg_write = 1'b0; cfg_base = 27'h500; cfg_count = 16'd2; cfg_pattern = 64'h77;
        start = 1'b1; bus.cmd_ready = 1'b1;
        @(negedge cpu_clk);
        start = 1'b0;
        @(negedge cpu_clk);
        @(negedge cpu_clk);
        bus.cmd_ready = 1'b0;
        chk("drain_busy",  64'(busy), 64'd1);
        chk("drain_valid", 64'(bus.cmd_valid), 64'd0);
        RESET_N = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        #39;
        RESET_N = 1'b1;
        @(negedge cpu_clk);
        chk("no_restart", 64'(busy), 64'd0);
        run(1'b0, 27'h600, 5, 64'hBEEF, 80, 60, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
